la_capture_reader: RTL and testbench

LA_CAPTURE_READER -- requirements
Module: la_capture_reader

---
 rtl/la_capture_reader.sv | 125 ++++++++++++
 tb/tb_la_capture_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_reader.sv
// Streams a captured logic-analyser window out of the capture RAM over 8N1 UART as header 0xA5, DEPTH samples, checksum.
// One RAM read is issued at the start of each byte, so the next sample is always ready before the current byte finishes.
module la_capture_reader #(
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256,
  parameter int CLK_DIV  = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_done,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [ADDR_W-1:0] PRE      = ADDR_W'(PRE_TRIG);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_K   = '1;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, FIN} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] byte_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        tx_byte;
  logic [7:0]        pend;
  logic [7:0]        csum;
  logic              rd_dly;
  logic              sending;
  logic              bit_end;
  logic              byte_end;
  logic              byte_begin;
  logic              last_data;
  logic [2:0]        bsel;

  assign sending    = (state == HDR) || (state == DATA) || (state == CSUM);
  assign bit_end    = (div_cnt == DIV_LAST);
  assign byte_end   = bit_end && (bit_cnt == 4'd9);
  assign byte_begin = sending && (bit_cnt == 4'd0) && (div_cnt == '0);
  assign last_data  = (state == DATA) && (byte_cnt == LAST_K);
  assign bsel       = 3'(bit_cnt - 4'd1);

  always_comb begin
    state_d = state;
    busy    = sending;
    done    = 1'b0;
    uart_tx = 1'b1;
    case (state)
      IDLE:    if (cap_done) state_d = HDR;
      HDR:     if (byte_end) state_d = DATA;
      DATA:    if (byte_end && last_data) state_d = CSUM;
      CSUM:    if (byte_end) state_d = FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bit 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
    if (sending) begin
      if (bit_cnt == 4'd0)       uart_tx = 1'b0;
      else if (bit_cnt <= 4'd8)  uart_tx = tx_byte[bsel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      byte_cnt  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_byte   <= '0;
      pend      <= '0;
      csum      <= '0;
      rd_dly    <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
    end else begin
      state     <= state_d;
      ram_rd_en <= 1'b0;
      rd_dly    <= ram_rd_en;
      if (rd_dly) begin
        pend <= ram_data;
        csum <= csum + ram_data;
      end
      if (state == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        if (cap_done) begin
          base     <= trig_addr - PRE;
          tx_byte  <= 8'hA5;
          csum     <= '0;
          byte_cnt <= '0;
        end
      end else if (sending) begin
        // The header fetches sample 0; data byte k fetches sample k+1, except the last one.
        if (byte_begin && ((state == HDR) || ((state == DATA) && !last_data))) begin
          ram_rd_en <= 1'b1;
          ram_addr  <= (state == HDR) ? base : ram_addr + 1'b1;
        end
        if (bit_end) begin
          div_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            bit_cnt <= '0;
            if (state == DATA) byte_cnt <= byte_cnt + 1'b1;
            tx_byte <= last_data ? csum : pend;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_la_capture_reader.sv
// Bench for la_capture_reader: decodes the UART line cycle by cycle and checks frames against literal or model-built byte lists.
module tb_la_capture_reader;
  localparam int ADDR_W   = 3;
  localparam int PRE_TRIG = 2;
  localparam int CLK_DIV  = 4;
  localparam int DEPTH    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cap_done = 1'b0;
  logic [ADDR_W-1:0] trig_addr = '0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              uart_tx;
  logic              busy;
  logic              done;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_log [$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int cur_byte = -1;

  always #5 clk = ~clk;

  la_capture_reader #(.ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cap_done(cap_done), .trig_addr(trig_addr),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (ram_rd_en === 1'b1) begin
      ram_data <= mem[ram_addr];
      rd_log.push_back(ram_addr);
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    n_cmp++;
    if (ram_rd_en === 1'b1 && busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_en_outside_frame: ram_rd_en=%b busy=%b, required ram_rd_en=0 when not busy", ram_rd_en, busy);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int trig, output logic [7:0] fr[$], output logic [ADDR_W-1:0] rd[$]);
    int base;
    int sum;
    fr.delete();
    rd.delete();
    base = (trig - PRE_TRIG + DEPTH) % DEPTH;
    sum = 0;
    fr.push_back(8'hA5);
    for (int k = 0; k < DEPTH; k++) begin
      rd.push_back(ADDR_W'((base + k) % DEPTH));
      fr.push_back(mem[(base + k) % DEPTH]);
      sum = (sum + mem[(base + k) % DEPTH]) % 256;
    end
    fr.push_back(8'(sum));
  endfunction

  task automatic start_frame(input logic [ADDR_W-1:0] trig);
    @(negedge clk);
    chk("busy_before_frame", busy, 1'b0);
    rd_log.delete();
    cur_byte = -1;
    cap_done = 1'b1;
    trig_addr = trig;
    @(negedge clk);
    cap_done = 1'b0;
    trig_addr = ADDR_W'($urandom);
    chk("busy_rise", busy, 1'b1);
  endtask

  // Returns early (at the start bit of byte stop_at) when stop_at >= 0.
  task automatic recv_frame(input logic [7:0] exp[$], input int stop_at);
    int idle;
    logic [7:0] got;
    logic expb;
    logic sv_tx;
    logic sv_busy;
    bit bad;
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) @(negedge clk);
      idle = 0;
      while (uart_tx === 1'b1 && idle < ((i == 0) ? 20 : 5)) begin
        @(negedge clk);
        idle++;
      end
      chk($sformatf("start_bit_byte%0d", i), uart_tx, 1'b0);
      if (uart_tx !== 1'b0) return;
      cur_byte = i;
      if (i == stop_at) return;
      got = '0;
      for (int b = 0; b < 10; b++) begin
        expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[i][b-1];
        bad = 0;
        sv_tx = expb;
        sv_busy = 1'b1;
        for (int c = 0; c < CLK_DIV; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (uart_tx !== expb || busy !== 1'b1) begin
            bad = 1;
            sv_tx = uart_tx;
            sv_busy = busy;
          end
          if (b >= 1 && b <= 8 && c == CLK_DIV / 2) got[b-1] = uart_tx;
        end
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL byte%0d_bit%0d: uart_tx=%b busy=%b, required uart_tx=%b busy=1 for %0d cycles",
                   i, b, sv_tx, sv_busy, expb, CLK_DIV);
        end
      end
      chk($sformatf("byte%0d_value", i), got, exp[i]);
    end
    idle = 0;
    @(negedge clk);
    while (done !== 1'b1 && idle < 6) begin
      @(negedge clk);
      idle++;
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("tx_in_done", uart_tx, 1'b1);
  endtask

  task automatic check_reads(input logic [ADDR_W-1:0] rd[$]);
    chk("read_count", rd_log.size(), rd.size());
    for (int k = 0; k < rd.size() && k < rd_log.size(); k++)
      chk($sformatf("read_addr_k%0d", k), rd_log[k], rd[k]);
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] trig, input logic [7:0] fr[$],
                           input logic [ADDR_W-1:0] rd[$], input bit poke);
    int d0;
    d0 = done_cnt;
    start_frame(trig);
    fork
      recv_frame(fr, -1);
      if (poke) begin
        int t;
        t = 0;
        while (cur_byte < 4 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        repeat (6) @(negedge clk);
        cap_done = 1'b1;
        trig_addr = 3'd2;
        @(negedge clk);
        cap_done = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_after_frame", busy, 1'b0);
    check_reads(rd);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [ADDR_W-1:0] rd[$];
    logic [7:0] fr5[$];
    logic [ADDR_W-1:0] rd5[$];
    int d0;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    fr5 = '{8'hA5, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12, 8'h9C};
    rd5 = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

    cap_done = 1'b1;
    trig_addr = 3'd5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_uart_tx", uart_tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ram_rd_en", ram_rd_en, 1'b0);
      chk("rst_ram_addr", ram_addr, 3'd0);
    end
    rst = 1'b0;
    cap_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst_busy", busy, 1'b0);
    chk("idle_after_rst_tx", uart_tx, 1'b1);

    run_frame(3'd5, fr5, rd5, 1'b0);

    fr = '{8'hA5, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h9C};
    rd = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    run_frame(3'd0, fr, rd, 1'b0);

    run_frame(3'd5, fr5, rd5, 1'b1);

    d0 = done_cnt;
    start_frame(3'd5);
    recv_frame(fr5, 5);
    #1 rst = 1'b1;
    #1;
    chk("abort_tx_async", uart_tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_hold_tx", uart_tx, 1'b1);
    chk("abort_hold_rd_en", ram_rd_en, 1'b0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", busy, 1'b0);
    run_frame(3'd5, fr5, rd5, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int trig;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      trig = $urandom_range(0, DEPTH - 1);
      model(trig, fr, rd);
      run_frame(ADDR_W'(trig), fr, rd, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
